mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single read/write port (port A) of the unified instruction/data memory (256 x 32 distributed RAM) between two requesters.
  - Requester 0: multicycle CPU core.
  - Requester 1: debug/loader engine.
- Round-robin arbitration; one access per grant; read data is registered and returned with a one-cycle ack pulse.
- Sits between the requesters and the memory wrapper. The memory's debug read port is not touched.

Parameters:
- AW, 8, address width (memory depth 2^AW words)
- DW, 32, data width

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- r0_req  in  1  requester 0 access request, held until r0_ack
- r0_we  in  1  requester 0 write enable (1 = write, 0 = read)
- r0_addr  in  AW  requester 0 word address
- r0_wdata  in  DW  requester 0 write data
- r0_ack  out  1  one-cycle completion pulse to requester 0
- r0_rdata  out  DW  read data to requester 0, valid while r0_ack = 1
- r1_req, r1_we, r1_addr, r1_wdata, r1_ack, r1_rdata  same as r0_*, for requester 1
- mem_addr  out  AW  memory port-A address
- mem_wdata  out  DW  memory port-A write data
- mem_we  out  1  memory port-A write enable (memory writes on clk edge)
- mem_rdata  in  DW  memory port-A asynchronous read data (spo)
- busy  out  1  high in ACCESS and RESP

Behaviour:
- Reset (asynchronous, rst_n = 0):
  - state = IDLE, last = 1 (requester 0 wins the first contention).
  - All outputs 0; latched addr/wdata/we/owner = 0.
- Requester contract:
  - req, we, addr and wdata stay stable from assertion until the ack cycle.
  - req drops in the cycle after ack.
- Arbitration (pick):
  - One requester eligible: grant it.
  - Both eligible: grant the one not equal to last.
  - Grant updates last and latches owner, addr, wdata and we into registers.
- FSM:
  - IDLE: if pick valid -> ACCESS (latch winner), else stay.
  - ACCESS: mem_addr/mem_wdata driven from latches; mem_we = latched we (this cycle only).
    - At the end-of-cycle edge: the write commits, or mem_rdata is captured into the owner's rdata register.
    - -> RESP.
  - RESP: owner's ack = 1 for exactly this cycle; rdata valid (0 for writes is not required, just hold the last value).
    - Arbitrate among requests excluding the owner (its req is still high).
    - Winner -> ACCESS (back-to-back); none -> IDLE.
- Latency: req seen in IDLE cycle N -> ACCESS N+1 -> ack in N+2.
- Throughput: one access per 2 cycles under continuous contention, alternating owners.
- mem_we is decoded from registered state only, with no combinational path from r*_we. mem_we = 0 in IDLE and RESP.
- mem_addr and mem_wdata hold their last values outside ACCESS.
- r0_ack and r1_ack are never high together.
- Mid-operation reset: state returns to IDLE immediately and mem_we drops asynchronously.
  - A write whose commit edge has not occurred is lost.
  - No ack is issued; requesters reissue after reset.
- Widths: addresses pass through unmodified; no arithmetic.

Decomposition:
- Package mem_arb_pkg:
  - state enum {IDLE, ACCESS, RESP}.
  - Default AW/DW constants.
  - Requester index constants REQ_CPU = 0, REQ_DBG = 1.
- One sub-module, rr_arb2: purely combinational two-way round-robin picker.
  - Inputs: req[1:0], mask[1:0], last.
  - Outputs: valid, winner.
  - The FSM and datapath registers stay in mem_port_arbiter.

Test Plan:
- Single read: mem[0x10] = 0xDEADBEEF, r0_req/addr = 0x10/we = 0 in cycle 0 -> mem_addr = 0x10 in cycle 1, r0_ack = 1 with r0_rdata = 0xDEADBEEF in cycle 2, r1_ack stays 0.
- Single write: r1 writes 0x12345678 to 0x3F -> mem_we = 1 only in cycle 1 with mem_addr = 0x3F; a later r0 read of 0x3F returns 0x12345678.
- Contention after reset: r0 and r1 both request in cycle 0.
  - r0 is granted first: r0_ack in cycle 2.
  - r1 goes to ACCESS in cycle 3 and r1_ack in cycle 4, with no IDLE gap.
- Sustained contention: both hold req continuously for 8 transactions -> acks alternate r0, r1, r0, ..., one every 2 cycles, and are never simultaneous.
- Mid-write reset: rst_n pulled low halfway through the ACCESS cycle of a write to 0x20 (old value 0xAAAA0000).
  - mem_we falls immediately and mem[0x20] remains 0xAAAA0000.
  - No ack; after release state is IDLE and all outputs are 0.
- Idle: no requests for 10 cycles -> busy = 0, mem_we = 0, no acks.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory port-A arbiter.
package mem_arb_pkg;

    localparam int AW_DEF  = 8;
    localparam int DW_DEF  = 32;

    localparam int REQ_CPU = 0;
    localparam int REQ_DBG = 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-way round-robin picker: masked requesters are ignored, ties go to the
// requester that did not win last.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic [1:0] mask,
    input  logic       last,
    output logic       valid,
    output logic       winner
);

    logic [1:0] elig;

    assign elig  = req & ~mask;
    assign valid = |elig;

    always_comb begin
        winner = 1'b0;
        case (elig)
            2'b01:   winner = 1'b0;
            2'b10:   winner = 1'b1;
            2'b11:   winner = ~last;
            default: winner = 1'b0;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin sharing of memory port A between the CPU (0) and the debug
// loader (1); one access per grant, registered read data, one-cycle ack.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,

    input  logic          r0_req,
    input  logic          r0_we,
    input  logic [AW-1:0] r0_addr,
    input  logic [DW-1:0] r0_wdata,
    output logic          r0_ack,
    output logic [DW-1:0] r0_rdata,

    input  logic          r1_req,
    input  logic          r1_we,
    input  logic [AW-1:0] r1_addr,
    input  logic [DW-1:0] r1_wdata,
    output logic          r1_ack,
    output logic [DW-1:0] r1_rdata,

    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rdata,

    output logic          busy
);

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } acc_t;

    arb_state_e           state, state_nxt;
    logic                 last_q;
    logic                 owner_q;
    acc_t                 lat_q;
    acc_t [1:0]           req_in;
    logic [1:0][DW-1:0]   rdata_q;

    logic [1:0]           req_vec;
    logic [1:0]           pick_mask;
    logic                 pick_valid;
    logic                 pick_win;
    logic                 grant;

    assign req_vec   = {r1_req, r0_req};
    assign req_in[0] = {r0_we, r0_addr, r0_wdata};
    assign req_in[1] = {r1_we, r1_addr, r1_wdata};

    // The owner keeps req high through its ack cycle, so it must not re-win in RESP.
    assign pick_mask = (state == RESP) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;

    rr_arb2 u_pick (
        .req    (req_vec),
        .mask   (pick_mask),
        .last   (last_q),
        .valid  (pick_valid),
        .winner (pick_win)
    );

    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    state_nxt = ACCESS;
                    grant     = 1'b1;
                end
            end
            ACCESS: state_nxt = RESP;
            RESP: begin
                if (pick_valid) begin
                    state_nxt = ACCESS;
                    grant     = 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            last_q  <= 1'b1;
            owner_q <= 1'b0;
            lat_q   <= '0;
        end else begin
            state <= state_nxt;
            if (grant) begin
                last_q  <= pick_win;
                owner_q <= pick_win;
                lat_q   <= req_in[pick_win];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (state == ACCESS && !lat_q.we) begin
            for (int i = 0; i < 2; i++) begin
                if (owner_q == 1'(i))
                    rdata_q[i] <= mem_rdata;
            end
        end
    end

    // Write strobe comes only from registered state, so reset kills it at once.
    assign mem_we    = (state == ACCESS) && lat_q.we;
    assign mem_addr  = lat_q.addr;
    assign mem_wdata = lat_q.wdata;
    assign busy      = (state != IDLE);

    assign r0_ack    = (state == RESP) && (owner_q == 1'(REQ_CPU));
    assign r1_ack    = (state == RESP) && (owner_q == 1'(REQ_DBG));
    assign r0_rdata  = rdata_q[REQ_CPU];
    assign r1_rdata  = rdata_q[REQ_DBG];

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized checks of mem_port_arbiter against a behavioural memory model.
module tb_mem_port_arbiter;

    localparam int AW = 8;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          r0_req = 0, r0_we = 0, r1_req = 0, r1_we = 0;
    logic [AW-1:0] r0_addr = '0, r1_addr = '0;
    logic [DW-1:0] r0_wdata = '0, r1_wdata = '0;
    logic          r0_ack, r1_ack, mem_we, busy;
    logic [DW-1:0] r0_rdata, r1_rdata, mem_wdata, mem_rdata;
    logic [AW-1:0] mem_addr;

    logic [DW-1:0] mem     [256];
    logic [DW-1:0] ref_mem [256];

    int n_cmp = 0;
    int n_err = 0;

    mem_port_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_ack(r0_ack), .r0_rdata(r0_rdata),
        .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_ack(r1_ack), .r1_rdata(r1_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;
    assign mem_rdata = mem[mem_addr];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int i, input logic rq, input logic we,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (i == 0) begin
            r0_req = rq; r0_we = we; r0_addr = a; r0_wdata = d;
        end else begin
            r1_req = rq; r1_we = we; r1_addr = a; r1_wdata = d;
        end
    endtask

    // Leaves the bench 1 time unit after a rising edge with the DUT out of reset.
    task automatic do_reset;
        drive(0, 0, 0, '0, '0);
        drive(1, 0, 0, '0, '0);
        rst_n = 1'b0;
        step;
        step;
        #2 rst_n = 1'b1;
        step;
    endtask

    // random-phase requester model
    logic          pend  [2];
    logic          p_we  [2];
    logic [AW-1:0] p_addr[2];
    logic [DW-1:0] p_wd  [2];
    int            p_iss [2];
    int            p_oth [2];
    logic          ackp  [2];
    logic          acks  [2];
    logic [DW-1:0] rds   [2];
    int            cyc;
    int            n0, n1;
    logic          prev0, prev1, e0, e1;
    logic [AW-1:0] a0, a1;

    initial begin
        foreach (mem[k]) mem[k] = $urandom;

        // reset state
        do_reset;
        chk("rst_busy", busy, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_acks", {r0_ack, r1_ack}, 0);
        chk("rst_rdata", {r0_rdata, r1_rdata}, 0);

        // single read by requester 0
        mem[8'h10] = 32'hDEADBEEF;
        drive(0, 1, 0, 8'h10, '0);
        step;
        chk("rd_c1_addr", mem_addr, 8'h10);
        chk("rd_c1_busy", busy, 1);
        chk("rd_c1_ack", r0_ack, 0);
        step;
        chk("rd_c2_ack0", r0_ack, 1);
        chk("rd_c2_rdata", r0_rdata, 32'hDEADBEEF);
        chk("rd_c2_ack1", r1_ack, 0);
        step;
        drive(0, 0, 0, '0, '0);
        chk("rd_c3_ack", r0_ack, 0);
        chk("rd_c3_busy", busy, 0);

        // single write by requester 1, then read back by requester 0
        drive(1, 1, 1, 8'h3F, 32'h12345678);
        step;
        chk("wr_c1_we", mem_we, 1);
        chk("wr_c1_addr", mem_addr, 8'h3F);
        chk("wr_c1_wdata", mem_wdata, 32'h12345678);
        step;
        chk("wr_c2_we", mem_we, 0);
        chk("wr_c2_ack1", r1_ack, 1);
        chk("wr_c2_ack0", r0_ack, 0);
        step;
        drive(1, 0, 0, '0, '0);
        drive(0, 1, 0, 8'h3F, '0);
        step;
        step;
        chk("rb_ack0", r0_ack, 1);
        chk("rb_rdata", r0_rdata, 32'h12345678);
        step;
        drive(0, 0, 0, '0, '0);

        // contention straight after reset: r0 first, r1 back-to-back
        do_reset;
        drive(0, 1, 0, 8'h10, '0);
        drive(1, 1, 0, 8'h3F, '0);
        step;
        chk("ct_c1_addr", mem_addr, 8'h10);
        step;
        chk("ct_c2_ack0", r0_ack, 1);
        chk("ct_c2_ack1", r1_ack, 0);
        chk("ct_c2_rdata", r0_rdata, 32'hDEADBEEF);
        step;
        chk("ct_c3_busy", busy, 1);
        chk("ct_c3_addr", mem_addr, 8'h3F);
        chk("ct_c3_ack0", r0_ack, 0);
        drive(0, 0, 0, '0, '0);
        step;
        chk("ct_c4_ack1", r1_ack, 1);
        chk("ct_c4_ack0", r0_ack, 0);
        chk("ct_c4_rdata", r1_rdata, 32'h12345678);
        step;
        drive(1, 0, 0, '0, '0);

        // sustained contention: 8 transactions alternating r0, r1
        do_reset;
        foreach (mem[k]) ref_mem[k] = mem[k];
        a0 = 8'($urandom); a1 = 8'($urandom);
        drive(0, 1, 0, a0, '0);
        drive(1, 1, 0, a1, '0);
        n0 = 0; n1 = 0; prev0 = 0; prev1 = 0;
        for (int c = 1; c <= 20; c++) begin
            step;
            e0 = (c >= 2 && c <= 16 && (c % 2) == 0 && (((c / 2) - 1) % 2) == 0);
            e1 = (c >= 2 && c <= 16 && (c % 2) == 0 && (((c / 2) - 1) % 2) == 1);
            chk("sus_ack0", r0_ack, e0);
            chk("sus_ack1", r1_ack, e1);
            if (r0_ack) chk("sus_rd0", r0_rdata, ref_mem[a0]);
            if (r1_ack) chk("sus_rd1", r1_rdata, ref_mem[a1]);
            if (prev0) begin
                n0++;
                if (n0 < 4) begin a0 = 8'($urandom); drive(0, 1, 0, a0, '0); end
                else drive(0, 0, 0, '0, '0);
            end
            if (prev1) begin
                n1++;
                if (n1 < 4) begin a1 = 8'($urandom); drive(1, 1, 0, a1, '0); end
                else drive(1, 0, 0, '0, '0);
            end
            prev0 = r0_ack;
            prev1 = r1_ack;
        end

        // reset in the middle of a write's ACCESS cycle
        do_reset;
        mem[8'h20] = 32'hAAAA0000;
        drive(0, 1, 1, 8'h20, 32'h55555555);
        step;
        chk("mr_we_before", mem_we, 1);
        #4 rst_n = 1'b0;
        #1;
        chk("mr_we_async", mem_we, 0);
        chk("mr_busy_async", busy, 0);
        drive(0, 0, 0, '0, '0);
        step;
        chk("mr_mem_kept", mem[8'h20], 32'hAAAA0000);
        chk("mr_no_ack", {r0_ack, r1_ack}, 0);
        #2 rst_n = 1'b1;
        step;
        chk("mr_out_zero", {busy, mem_we, r0_ack, r1_ack, mem_addr, mem_wdata}, 0);
        chk("mr_rdata_zero", {r0_rdata, r1_rdata}, 0);

        // idle
        for (int c = 0; c < 10; c++) begin
            step;
            chk("idle", {busy, mem_we, r0_ack, r1_ack}, 0);
        end

        // randomized traffic against a serialized memory model
        foreach (mem[k]) ref_mem[k] = mem[k];
        for (int i = 0; i < 2; i++) begin
            pend[i] = 0; ackp[i] = 0; p_iss[i] = 0; p_oth[i] = 0;
            p_we[i] = 0; p_addr[i] = '0; p_wd[i] = '0;
        end
        cyc = 0;
        for (int t = 0; t < 420; t++) begin
            step;
            cyc++;
            acks[0] = r0_ack; acks[1] = r1_ack;
            rds[0]  = r0_rdata; rds[1] = r1_rdata;
            chk("rnd_excl", acks[0] & acks[1], 0);
            for (int i = 0; i < 2; i++) begin
                if (acks[i]) begin
                    if (!pend[i] || ackp[i]) chk("rnd_spurious", 1, 0);
                    else begin
                        chk("rnd_lat_ok", (cyc - p_iss[i] >= 2) && (cyc - p_iss[i] <= 4), 1);
                        chk("rnd_fair", p_oth[i] <= 1, 1);
                        if (p_we[i]) ref_mem[p_addr[i]] = p_wd[i];
                        else chk("rnd_rdata", rds[i], ref_mem[p_addr[i]]);
                    end
                end else if (pend[i] && !ackp[i] && acks[1-i]) begin
                    p_oth[i]++;
                end
            end
            for (int i = 0; i < 2; i++) begin
                if (acks[i]) begin
                    ackp[i] = 1;
                end else begin
                    if (ackp[i]) begin
                        ackp[i] = 0;
                        pend[i] = 0;
                        drive(i, 0, 0, '0, '0);
                    end
                    if (pend[i] && cyc - p_iss[i] > 8) begin
                        chk("rnd_timeout", 1, 0);
                        pend[i] = 0;
                        drive(i, 0, 0, '0, '0);
                    end
                    if (!pend[i] && t < 400 && $urandom_range(0, 9) < 5) begin
                        pend[i]   = 1;
                        p_we[i]   = 1'($urandom);
                        p_addr[i] = 8'h40 + 8'($urandom_range(0, 7));
                        p_wd[i]   = $urandom;
                        p_iss[i]  = cyc;
                        p_oth[i]  = 0;
                        drive(i, 1, p_we[i], p_addr[i], p_wd[i]);
                    end
                end
            end
        end
        chk("rnd_drained", {pend[0], pend[1]}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
